// File: rtl/jk_pkg.sv
// Shared JK flip-flop control codes used by the counter and its storage cells.
package jk_pkg;

   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_CLR  = 2'b01,
      JK_SET  = 2'b10,
      JK_TGL  = 2'b11
   } jk_code_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK storage bit with synchronous active-high clear.
module jk_cell
   import jk_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] jk,
   output logic       q,
   output logic       qb
);

   // Power-up value keeps q/qb defined before the first reset edge.
   logic state_q = 1'b0;
   logic state_d;

   always_comb begin
      state_d = state_q;
      case (jk_code_e'(jk))
         JK_HOLD: state_d = state_q;
         JK_CLR:  state_d = 1'b0;
         JK_SET:  state_d = 1'b1;
         JK_TGL:  state_d = ~state_q;
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= 1'b0;
      else     state_q <= state_d;
   end

   assign q  = state_q;
   assign qb = ~state_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-N up/down counter with parallel load, built from JK storage cells.
module jk_sync_counter
   import jk_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc,
   output logic             wrap
);

   // One extra bit so MODULUS == 2**WIDTH still compares correctly.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] cnt_nxt;
   logic [WIDTH-1:0] j_bits;
   logic [WIDTH-1:0] k_bits;
   logic             wrap_q = 1'b0;
   logic             wrap_d;

   always_comb begin
      cnt_nxt = q;
      tc      = 1'b0;
      if (load) begin
         cnt_nxt = ({1'b0, din} < MOD_EXT) ? din : '0;
      end else if (en) begin
         if (up) begin
            tc      = (q == Q_MAX);
            cnt_nxt = tc ? '0 : q + WIDTH'(1);
         end else begin
            tc      = (q == '0);
            cnt_nxt = tc ? Q_MAX : q - WIDTH'(1);
         end
      end
      tc     = tc & ~rst;
      j_bits = cnt_nxt & ~q;
      k_bits = ~cnt_nxt & q;
      wrap_d = load ? 1'b0 : (wrap_q | tc);
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .jk  ({j_bits[i], k_bits[i]}),
         .q   (q[i]),
         .qb  (qb[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) wrap_q <= 1'b0;
      else     wrap_q <= wrap_d;
   end

   assign wrap = wrap_q;

endmodule
